// File: rtl/replay_pkg.sv
// Shared definitions for the replay block: FSM state encoding and the
// geometry of the input FIFO.
package replay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

  localparam int unsigned IN_FIFO_DEPTH     = 4;
  localparam int unsigned IN_FIFO_LOG_DEPTH = 2;

endpackage

// File: rtl/FIFO.sv
// Small synchronous FIFO with a combinational head (first-word fall-through).
// almost_full is raised with one slot left so a producer that reacts one
// cycle late still has room for a final write.
module FIFO #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_full
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH:0]   r_count;
  logic                 w_push;
  logic                 w_pop;

  assign w_push        = i_wr_en & ~o_full;
  assign w_pop         = i_rd_en & ~o_empty;
  assign o_empty       = (r_count == '0);
  assign o_full        = (r_count == (LOG_DEPTH+1)'(DEPTH));
  assign o_almost_full = (r_count == (LOG_DEPTH+1)'(DEPTH - 1));
  assign o_rd_data     = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (LOG_DEPTH+1)'(1);
        2'b01:   r_count <= r_count - (LOG_DEPTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/MEMU.sv
// Simple dual-port memory: synchronous write, asynchronous read. A write at
// one edge is visible to the read in the following cycle.
module MEMU #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 65536,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_raddr];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

endmodule

// File: rtl/replay_ctrl.sv
// Sequencer for replay: FSM, addr/iter counters and the done pulse.
// With REPLAY_DEBUG_EN defined, the iteration counter is also exported.
module replay_ctrl
  import replay_pkg::*;
#(
  parameter int unsigned LOG_MAX_ITERS          = 16,
  parameter int unsigned LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_configure,
  input  logic [LOG_MAX_ITERS-1:0]          i_num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] i_num_reads,
  input  logic                              i_avail_in,
  input  logic                              i_fifo_empty,
  output state_t                            o_state,
  output logic                              o_op,
  output logic [LOG_MAX_READS_PER_ITER-1:0] o_addr,
`ifdef REPLAY_DEBUG_EN
  output logic [LOG_MAX_ITERS-1:0]          o_iter,
`endif
  output logic                              o_done
);

  state_t                            r_state;
  logic [LOG_MAX_READS_PER_ITER-1:0] r_addr;
  logic [LOG_MAX_ITERS-1:0]          r_iter;
  logic [LOG_MAX_ITERS-1:0]          r_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0] r_reads;
  logic                              r_done;
  logic                              w_op;

  // configure always wins over a transfer in the same cycle.
  assign w_op = ~i_configure & i_avail_in &
                (((r_state == ST_FILL) & ~i_fifo_empty) | (r_state == ST_REPLAY));

  assign o_state = r_state;
  assign o_op    = w_op;
  assign o_addr  = r_addr;
  assign o_done  = r_done;
`ifdef REPLAY_DEBUG_EN
  assign o_iter  = r_iter;
`endif

  // Job sequencing: latch on configure, step addr/iter on each transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_iter  <= '0;
      r_iters <= '0;
      r_reads <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_configure) begin
        r_iters <= i_num_iters;
        r_reads <= i_num_reads;
        r_addr  <= '0;
        r_iter  <= '0;
        if ((i_num_iters == '0) || (i_num_reads == '0)) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_state <= ST_FILL;
        end
      end else if (w_op) begin
        if (r_addr == r_reads - LOG_MAX_READS_PER_ITER'(1)) begin
          r_addr <= '0;
          if (r_iter == r_iters - LOG_MAX_ITERS'(1)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_iter  <= r_iter + LOG_MAX_ITERS'(1);
            r_state <= ST_REPLAY;
          end
        end else begin
          r_addr <= r_addr + LOG_MAX_READS_PER_ITER'(1);
        end
      end
    end
  end

endmodule

// File: rtl/replay.sv
// replay: streams one pass of groups from upstream (forwarding and storing
// them), then re-emits the stored pass for the remaining iterations.
// Optional feature: define REPLAY_DEBUG_EN for a cycle counter and a
// per-transfer trace message; ports and timing are unchanged either way.
module replay
  import replay_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned GROUP_SIZE             = 4,
  parameter int unsigned LOG_MAX_ITERS          = 16,
  parameter int unsigned NUM_ADDRESSES          = 65536,
  parameter int unsigned LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               configure,
  input  logic [LOG_MAX_ITERS-1:0]           num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]  num_reads_per_iter,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]   data_in,
  input  logic                               valid_in,
  output logic                               avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0]   data_out,
  output logic                               valid_out,
  input  logic                               avail_in,
  output logic                               done
);

  localparam int unsigned BUS_W = GROUP_SIZE * DATA_WIDTH;

  logic [BUS_W-1:0]                  w_fifo_head;
  logic                              w_fifo_empty;
  logic                              w_fifo_full;
  logic                              w_fifo_almost_full;
  logic [BUS_W-1:0]                  w_mem_rdata;
  state_t                            w_state;
  logic                              w_op;
  logic [LOG_MAX_READS_PER_ITER-1:0] w_addr;
  logic                              w_done;
  logic                              w_fill;
  logic                              w_pop;
`ifdef REPLAY_DEBUG_EN
  logic [LOG_MAX_ITERS-1:0]          w_iter;
`endif

  assign w_fill = (w_state == ST_FILL);
  // Only the first pass consumes input; the same transfer also stores it.
  assign w_pop  = w_op & w_fill;

  replay_ctrl #(
    .LOG_MAX_ITERS          (LOG_MAX_ITERS),
    .LOG_MAX_READS_PER_ITER (LOG_MAX_READS_PER_ITER)
  ) u_ctrl (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_configure  (configure),
    .i_num_iters  (num_iters),
    .i_num_reads  (num_reads_per_iter),
    .i_avail_in   (avail_in),
    .i_fifo_empty (w_fifo_empty),
    .o_state      (w_state),
    .o_op         (w_op),
    .o_addr       (w_addr),
`ifdef REPLAY_DEBUG_EN
    .o_iter       (w_iter),
`endif
    .o_done       (w_done)
  );

  FIFO #(
    .WIDTH     (BUS_W),
    .LOG_DEPTH (IN_FIFO_LOG_DEPTH)
  ) u_fifo (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_en       (valid_in),
    .i_wr_data     (data_in),
    .i_rd_en       (w_pop),
    .o_rd_data     (w_fifo_head),
    .o_empty       (w_fifo_empty),
    .o_full        (w_fifo_full),
    .o_almost_full (w_fifo_almost_full)
  );

  MEMU #(
    .WIDTH  (BUS_W),
    .DEPTH  (NUM_ADDRESSES),
    .ADDR_W (LOG_MAX_READS_PER_ITER)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_pop),
    .i_waddr (w_addr),
    .i_wdata (w_fifo_head),
    .i_raddr (w_addr),
    .o_rdata (w_mem_rdata)
  );

  assign avail_out = ~w_fifo_almost_full & ~w_fifo_full;
  assign valid_out = w_op;
  assign data_out  = w_fill ? w_fifo_head : w_mem_rdata;
  assign done      = w_done;

`ifdef REPLAY_DEBUG_EN
  logic [15:0] r_tics;

  // Free-running cycle counter for trace messages.
  always_ff @(posedge clk) begin
    if (rst) r_tics <= '0;
    else     r_tics <= r_tics + 16'd1;
  end

  // Trace every transferred group.
  always_ff @(posedge clk) begin
    if (!rst && w_op)
      $display("REPLAY: cycle %d iter %d addr %d data %h", r_tics, w_iter, w_addr, data_out);
  end
`endif

endmodule

// File: tb/tb_replay.sv
// Bench for replay: a queue-based model of the job (first pass drawn from
// the upstream queue, later passes indexed from the captured pass) checked
// every cycle, plus literal per-test output logs.
module tb_replay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        configure = 1'b0;
  logic [15:0] num_iters = '0;
  logic [15:0] num_reads_per_iter = '0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        avail_in = 1'b1;
  logic        avail_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  replay #(
    .DATA_WIDTH             (8),
    .GROUP_SIZE             (4),
    .LOG_MAX_ITERS          (16),
    .NUM_ADDRESSES          (65536),
    .LOG_MAX_READS_PER_ITER (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .configure          (configure),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .data_in            (data_in),
    .valid_in           (valid_in),
    .avail_out          (avail_out),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .avail_in           (avail_in),
    .done               (done)
  );

  always #5 clk = ~clk;

  // Model state
  logic [31:0] in_q[$];
  logic [31:0] job[$];
  bit          started = 1'b0;
  bit          active = 1'b0;
  bit          exp_done = 1'b0;
  int unsigned m_iters = 0;
  int unsigned m_reads = 0;
  int unsigned k = 0;
  int unsigned cyc = 0;

  // Observation logs for literal checks
  logic [31:0] out_log[$];
  int unsigned cyc_log[$];
  logic [31:0] exp_lit[$];
  int unsigned done_cnt = 0;
  bit          toggle_en = 1'b0;

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    bit          ev;
    logic [31:0] e;
    cyc++;
    if (rst) begin
      started = 1'b1;
      in_q.delete();
      job.delete();
      active   = 1'b0;
      exp_done = 1'b0;
      k        = 0;
    end else if (started) begin
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done cyc=%0d got %b expected %b", cyc, done, exp_done);
      end
      checks++;
      if (avail_out !== (in_q.size() < 3)) begin
        errors++;
        $display("FAIL avail_out cyc=%0d got %b expected %b", cyc, avail_out, (in_q.size() < 3));
      end
      ev = active && !configure && avail_in && ((k >= m_reads) ? 1'b1 : (in_q.size() > 0));
      checks++;
      if (valid_out !== ev) begin
        errors++;
        $display("FAIL valid_out cyc=%0d got %b expected %b", cyc, valid_out, ev);
      end
      if (ev) begin
        e = (k < m_reads) ? in_q[0] : job[k % m_reads];
        checks++;
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out cyc=%0d xfer=%0d got %h expected %h", cyc, k, data_out, e);
        end
      end
      if (valid_out === 1'b1) begin
        out_log.push_back(data_out);
        cyc_log.push_back(cyc);
      end
      if (done === 1'b1) done_cnt++;

      exp_done = 1'b0;
      if (configure) begin
        m_iters = num_iters;
        m_reads = num_reads_per_iter;
        k = 0;
        job.delete();
        if (m_iters == 0 || m_reads == 0) begin
          active   = 1'b0;
          exp_done = 1'b1;
        end else begin
          active = 1'b1;
        end
      end else if (ev) begin
        if (k < m_reads) job.push_back(in_q.pop_front());
        k++;
        if (k == m_iters * m_reads) begin
          active   = 1'b0;
          exp_done = 1'b1;
        end
      end
      if (valid_in) in_q.push_back(data_in);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) avail_in = ~avail_in;
  endtask

  task automatic step(input bit cfg, input logic [15:0] it, input logic [15:0] rd,
                      input bit vin, input logic [31:0] d);
    configure          = cfg;
    num_iters          = it;
    num_reads_per_iter = rd;
    valid_in           = vin;
    data_in            = d;
    tick();
    configure = 1'b0;
    valid_in  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned target);
    int unsigned n = 0;
    while (done_cnt < target && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s timeout: done count %0d required %0d", name, done_cnt, target);
    end
    tick();
    tick();
  endtask

  task automatic check_log(input string name, input int unsigned exp_dn);
    logic [31:0] v;
    checks++;
    if (out_log.size() != exp_lit.size()) begin
      errors++;
      $display("FAIL %s length: got %0d required %0d", name, out_log.size(), exp_lit.size());
    end
    for (int i = 0; i < exp_lit.size(); i++) begin
      v = (i < out_log.size()) ? out_log[i] : 32'hxxxxxxxx;
      checks++;
      if (v !== exp_lit[i]) begin
        errors++;
        $display("FAIL %s item %0d: got %h required %h", name, i, v, exp_lit[i]);
      end
    end
    checks++;
    if (done_cnt != exp_dn) begin
      errors++;
      $display("FAIL %s done pulses: got %0d required %0d", name, done_cnt, exp_dn);
    end
    out_log.delete();
    cyc_log.delete();
    done_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    out_log.delete();
    cyc_log.delete();
    done_cnt = 0;

    // Basic: 3 passes of 4 groups
    step(1'b1, 16'd3, 16'd4, 1'b1, 32'h01);
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h02);
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h03);
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h04);
    wait_done("basic", 1);
    exp_lit = {32'h01, 32'h02, 32'h03, 32'h04, 32'h01, 32'h02, 32'h03, 32'h04,
               32'h01, 32'h02, 32'h03, 32'h04};
    check_log("basic", 1);

    // Pass-through
    step(1'b1, 16'd1, 16'd2, 1'b1, 32'h0A);
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h0B);
    wait_done("passthru", 1);
    exp_lit = {32'h0A, 32'h0B};
    check_log("passthru", 1);

    // Single entry, no bubble between FILL and REPLAY
    step(1'b1, 16'd4, 16'd1, 1'b1, 32'h55);
    wait_done("single", 1);
    checks++;
    if (cyc_log.size() != 4 || (cyc_log[3] - cyc_log[0]) != 3) begin
      errors++;
      $display("FAIL single consecutive: got %0d transfers spanning %0d cycles, required 4 spanning 3",
               cyc_log.size(), (cyc_log.size() == 4) ? (cyc_log[3] - cyc_log[0]) : 0);
    end
    exp_lit = {32'h55, 32'h55, 32'h55, 32'h55};
    check_log("single", 1);

    // Backpressure: avail_in toggles every cycle
    avail_in  = 1'b1;
    toggle_en = 1'b1;
    step(1'b1, 16'd2, 16'd3, 1'b1, 32'h11);
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h22);
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h33);
    wait_done("backpressure", 1);
    toggle_en = 1'b0;
    avail_in  = 1'b1;
    exp_lit = {32'h11, 32'h22, 32'h33, 32'h11, 32'h22, 32'h33};
    check_log("backpressure", 1);

    // Abort in REPLAY; queued input feeds the new job
    step(1'b1, 16'd3, 16'd2, 1'b1, 32'h61);
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h62);
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h71);
    for (int i = 0; i < 50 && out_log.size() < 3; i++) tick();
    step(1'b1, 16'd1, 16'd1, 1'b0, 32'h0);
    wait_done("abort", 1);
    exp_lit = {32'h61, 32'h62, 32'h61, 32'h71};
    check_log("abort", 1);

    // Reset mid-FILL
    step(1'b1, 16'd2, 16'd3, 1'b1, 32'h81);
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h82);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || avail_out !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_fill: got valid_out=%b avail_out=%b done=%b required 0 1 0",
               valid_out, avail_out, done);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    exp_lit = {32'h81, 32'h82};
    check_log("rst_mid_fill", 0);

    // Zero-count jobs leave queued input alone
    step(1'b0, 16'd0, 16'd0, 1'b1, 32'h91);
    step(1'b1, 16'd0, 16'd5, 1'b0, 32'h0);
    tick();
    tick();
    step(1'b1, 16'd2, 16'd0, 1'b0, 32'h0);
    tick();
    tick();
    step(1'b1, 16'd1, 16'd1, 1'b0, 32'h0);
    wait_done("zero", 3);
    exp_lit = {32'h91};
    check_log("zero", 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/replay.md
# replay

Replays one input pass to downstream consumers. Streams `num_reads_per_iter` groups from upstream once, forwards each group immediately and stores it in a local memory. It then re-emits the stored sequence from memory for the remaining `num_iters - 1` iterations without consuming further input. This is the read-side counterpart of the accumulator: it feeds the same activation/weight tile to a consumer that needs several passes, where the accumulator collapses several passes into one.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of one item.
- `GROUP_SIZE`, 4: items per group; bus width is `GROUP_SIZE*DATA_WIDTH`.
- `LOG_MAX_ITERS`, 16: width of the iteration count.
- `NUM_ADDRESSES`, 65536: memory depth in groups.
- `LOG_MAX_READS_PER_ITER`, 16: width of reads-per-iteration and of the memory address.

Ports (one clock; reset is synchronous and active-high):
- `clk` in, 1: clock.
- `rst` in, 1: synchronous, active-high reset.
- `configure` in, 1: loads the job.
- `num_iters` in, `LOG_MAX_ITERS`: total passes emitted, including the first.
- `num_reads_per_iter` in, `LOG_MAX_READS_PER_ITER`: groups per pass.
- `data_in` in, `GROUP_SIZE*DATA_WIDTH`: upstream data.
- `valid_in` in, 1: upstream write strobe.
- `avail_out` out, 1: upstream may send.
- `data_out` out, `GROUP_SIZE*DATA_WIDTH`: downstream data.
- `valid_out` out, 1: one group transferred this cycle.
- `avail_in` in, 1: downstream can accept.
- `done` out, 1: one-cycle pulse after the final group of the job.

## Operation
- Input FIFO: 4 slots.
  - `avail_out = ~almost_full & ~full`.
  - Upstream may write one group after `avail_out` falls.
- FSM states: IDLE, FILL, REPLAY.
- `op` (transfer this cycle) = `~configure & avail_in & ((FILL & ~empty) | REPLAY)`.
- FILL:
  - `data_out` = FIFO head.
  - On `op`: pop FIFO and write the head to memory at address `addr`.
- REPLAY:
  - `data_out` = memory read at `addr` (unregistered read).
  - FIFO is not popped. Input arriving now stays queued for the next job.
- IDLE: `valid_out = 0`. `data_out` is don't-care.
- `valid_out = op`.
- Counters: `addr` counts 0..`reads-1`; `iter` counts 0..`iters-1`.
- On `op` with `addr == reads-1`:
  - `addr <= 0`.
  - If `iter == iters-1`: go to IDLE and pulse `done` next cycle.
  - Otherwise: `iter++` and go to REPLAY.
- On `op` otherwise: `addr++`.
- `configure` in any state:
  - Latches both counts and clears `addr` and `iter`.
  - Goes to FILL. If either count is 0, goes to IDLE and pulses `done` next cycle.
  - Aborts any job in flight. FIFO contents are preserved.
- `configure` and a would-be `op` in the same cycle: `configure` wins, no transfer occurs.
- `num_iters == 1`: pure pass-through. Memory is written but never read.
- `num_reads_per_iter > NUM_ADDRESSES` is unsupported; the address wraps modulo `2^LOG_MAX_READS_PER_ITER`.

## Timing
- `rst` sampled high:
  - state IDLE, `addr = iter = 0`, latched counts 0.
  - FIFO emptied; `valid_out = 0`, `done = 0`.
  - `avail_out = 1` from the following cycle.
- Latency:
  - FILL: 0 cycles from FIFO head to `data_out`. A group written at edge N can appear at edge N+1.
  - First REPLAY group: earliest the cycle after the last FILL transfer. The memory write at that edge must be visible to the read; this must hold for `reads == 1`.
- Throughput: 1 group/cycle when `avail_in` is high. In FILL, throughput is also bounded by FIFO occupancy.
- `rst` mid-job: the job is dropped immediately, with no `done` pulse.
- `valid_out` and `data_out` are combinational from state, FIFO and memory. They depend on `avail_in` in the same cycle, as in the rest of the pipeline.

## Configuration
- `REPLAY_DEBUG_EN` defined:
  - Adds a 16-bit `tics` cycle counter, cleared by `rst`.
  - On every `op`: `$display("REPLAY: cycle %d iter %d addr %d data %h")`.
- `REPLAY_DEBUG_EN` undefined:
  - No `tics` register and no display.
  - Ports and cycle behaviour are identical.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, FILL=2'd1, REPLAY=2'd2.
  - Input FIFO depth constants: 4 slots, log2 = 2.
- Instantiates the existing `FIFO` and `MEMU`, with the memory sized by `NUM_ADDRESSES` and `LOG_MAX_READS_PER_ITER`.
- Natural sub-module `replay_ctrl` holds the FSM, the `addr`/`iter` counters and `done` generation. The top level is datapath muxing only.

## Test plan
- Basic: iters=3, reads=4; input groups 0x01..0x04; `avail_in` held 1.
  -> 12 `valid_out` pulses: 01,02,03,04 repeated three times.
  -> Exactly 4 FIFO pops, then `done` pulses once.
- Pass-through: iters=1, reads=2; inputs 0xA, 0xB.
  -> Output 0xA, 0xB.
  -> `done` pulse one cycle after 0xB.
- Single-entry: iters=4, reads=1; input 0x55.
  -> 0x55 on 4 consecutive cycles, with no bubble after the FILL transfer.
- Backpressure: iters=2, reads=3; `avail_in` toggled 1,0,1,0…
  -> `valid_out` only in cycles with `avail_in` high.
  -> Order preserved; total 6 transfers.
- Abort and reset:
  - `configure` in REPLAY mid-pass with new job iters=1, reads=1 -> the old job stops, the next output is the FIFO head, then `done`.
  - `rst` asserted mid-FILL -> `valid_out = 0` and `avail_out = 1` the next cycle, with no `done`.
- Zero config: iters=0 or reads=0.
  -> No `valid_out`, no FIFO pop.
  -> `done` pulse the cycle after `configure`.
